// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle between a producer and uart_tx.
interface uart_tx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]    TX_DATA;
    logic          TX_VALID;
    logic          TX_READY;
    logic          TX;
    logic          BUSY;
    logic [CW-1:0] FIFO_COUNT;

    modport master (
        output TX_DATA, TX_VALID,
        input  TX_READY, TX, BUSY, FIFO_COUNT
    );

    modport slave (
        input  TX_DATA, TX_VALID,
        output TX_READY, TX, BUSY, FIFO_COUNT
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a byte FIFO; frames are 10*CPB cycles, LSB first.
// Latency: TX falls in the cycle after the byte is popped (2 edges after accept into an idle, empty FIFO).
// Backpressure: TX_READY low while the FIFO is full; pushes while full are silently dropped.
module uart_tx #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic    CLK_25MHZ,
    input  logic    RESET_N,
    uart_tx_if.slave bus
);
    localparam int CPB = CLK_HZ / BAUD;
    localparam int TW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam logic [TW-1:0] RELOAD = TW'(CPB - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    state_t        state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic [2:0]    bit_cnt, bit_cnt_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          tx_q, tx_nxt;
    logic          bit_end;

    assign bus.TX_READY   = (count != CW'(FIFO_DEPTH));
    assign push           = bus.TX_VALID && bus.TX_READY;
    assign bus.FIFO_COUNT = count;
    assign bus.BUSY       = (state != IDLE) || (count != '0);
    assign bus.TX         = tx_q;

    // Storage is deliberately left out of reset; only pointers and count clear.
    always_ff @(posedge CLK_25MHZ) begin
        if (push)
            mem[wr_ptr] <= bus.TX_DATA;
    end

    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            tx_q    <= tx_nxt;
        end
    end

    assign bit_end = (timer == '0);

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        pop         = 1'b0;
        tx_nxt      = 1'b1;

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    shreg_nxt = mem[rd_ptr];
                    timer_nxt = RELOAD;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_nxt   = RELOAD;
                    bit_cnt_nxt = '0;
                    state_nxt   = DATA;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_nxt = RELOAD;
                    shreg_nxt = {1'b0, shreg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when more data waits.
                    if (count != '0) begin
                        pop       = 1'b1;
                        shreg_nxt = mem[rd_ptr];
                        timer_nxt = RELOAD;
                        state_nxt = START;
                    end else begin
                        timer_nxt = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase

        // Line level follows the upcoming state so the output is a clean flop.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// Scoreboarded bench: stimulus queues expected bytes, a line monitor decodes frames and compares.
module tb_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   frames = 0;
    logic [7:0] exp_q[$];
    int   starts_q[$];

    logic [7:0] m_got;
    logic [7:0] m_exp;
    bit   m_ok;
    bit   m_abort;
    int   m_start;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_if #(.FIFO_DEPTH(4)) bus ();
    uart_tx_if #(.FIFO_DEPTH(16)) bus2 ();

    uart_tx #(.CLK_HZ(4), .BAUD(1), .FIFO_DEPTH(4)) dut (
        .CLK_25MHZ(clk),
        .RESET_N  (rst_n),
        .bus      (bus)
    );

    uart_tx dut_def (
        .CLK_25MHZ(clk),
        .RESET_N  (rst_n),
        .bus      (bus2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && bus.BUSY == 1'b0)) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                checks++;
                errors++;
                $display("FAIL %s: timeout after %0d cycles, %0d bytes outstanding", name, n, exp_q.size());
                return;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    // Line monitor: decode one 8N1 frame per falling start bit, every bit exactly CPB samples.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.TX === 1'b0) begin
                m_start = cyc;
                m_ok    = 1'b1;
                m_abort = 1'b0;
                m_got   = '0;
                for (int c = 1; c < CPB; c++) begin
                    @(negedge clk);
                    if (!rst_n) m_abort = 1'b1;
                    else if (bus.TX !== 1'b0) m_ok = 1'b0;
                end
                for (int b = 0; b < 8; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        @(negedge clk);
                        if (!rst_n) m_abort = 1'b1;
                        else if (c == 0) m_got[b] = bus.TX;
                        else if (bus.TX !== m_got[b]) m_ok = 1'b0;
                    end
                end
                for (int c = 0; c < CPB; c++) begin
                    @(negedge clk);
                    if (!rst_n) m_abort = 1'b1;
                    else if (bus.TX !== 1'b1) m_ok = 1'b0;
                end
                if (!m_abort) begin
                    frames++;
                    starts_q.push_back(m_start);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got %0h expected none", m_got);
                    end else begin
                        m_exp = exp_q.pop_front();
                        check("frame_timing_ok", 32'(m_ok), 32'd1);
                        check("frame_byte", 32'(m_got), 32'(m_exp));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int n;
        logic [7:0] full_bytes [6];
        logic [7:0] wrap_bytes [4];
        full_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        wrap_bytes = '{8'hC3, 8'h3C, 8'h81, 8'h7E};

        rst_n = 1'b0;
        bus.TX_VALID  = 1'b0;
        bus.TX_DATA   = '0;
        bus2.TX_VALID = 1'b0;
        bus2.TX_DATA  = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus.TX), 32'd1);
        check("rst_ready", 32'(bus.TX_READY), 32'd1);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_count", 32'(bus.FIFO_COUNT), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single byte 0x55 into an idle, empty FIFO; j counts edges after the accept edge.
        bus.TX_DATA = 8'h55; bus.TX_VALID = 1'b1; exp_q.push_back(8'h55);
        @(posedge clk); #1 bus.TX_VALID = 1'b0;
        for (int j = 0; j <= 41; j++) begin
            @(negedge clk);
            if (j == 0) check("single_count_1", 32'(bus.FIFO_COUNT), 32'd1);
            if (j == 0) check("single_tx_idle", 32'(bus.TX), 32'd1);
            if (j == 1) check("single_tx_start", 32'(bus.TX), 32'd0);
            if (j == 4) check("single_tx_start_end", 32'(bus.TX), 32'd0);
            if (j == 5) check("single_tx_bit0", 32'(bus.TX), 32'd1);
            if (j == 9) check("single_tx_bit1", 32'(bus.TX), 32'd0);
            if (j == 40) check("single_busy_stop", 32'(bus.BUSY), 32'd1);
            if (j == 41) check("single_busy_low", 32'(bus.BUSY), 32'd0);
        end
        wait_done("single", 100);

        // Back-to-back pushes: second start bit right after first stop bit.
        starts_q.delete();
        bus.TX_DATA = 8'hA3; bus.TX_VALID = 1'b1; exp_q.push_back(8'hA3);
        @(posedge clk); #1 bus.TX_DATA = 8'h0F; exp_q.push_back(8'h0F);
        @(posedge clk); #1 bus.TX_VALID = 1'b0;
        wait_done("b2b", 200);
        if (starts_q.size() != 2) check("b2b_frames", 32'(starts_q.size()), 32'd2);
        else check("b2b_gap", 32'(starts_q[1] - starts_q[0]), 32'(10 * CPB));

        // Full FIFO: five accepted, sixth dropped while full.
        f0 = frames;
        for (int i = 0; i < 5; i++) begin
            bus.TX_DATA = full_bytes[i]; bus.TX_VALID = 1'b1; exp_q.push_back(full_bytes[i]);
            @(posedge clk); #1;
            if (i == 3) check("full_ready_at_3", 32'(bus.TX_READY), 32'd1);
        end
        @(negedge clk);
        check("full_count_4", 32'(bus.FIFO_COUNT), 32'd4);
        check("full_ready_0", 32'(bus.TX_READY), 32'd0);
        bus.TX_DATA = full_bytes[5];
        @(posedge clk); #1 bus.TX_VALID = 1'b0;
        @(negedge clk);
        check("full_drop_count", 32'(bus.FIFO_COUNT), 32'd4);
        wait_done("full", 400);
        check("full_frames_5", 32'(frames - f0), 32'd5);

        // Push coinciding with the pop at the end of a stop bit, pointers wrapping.
        for (int i = 0; i < 3; i++) begin
            bus.TX_DATA = wrap_bytes[i]; bus.TX_VALID = 1'b1; exp_q.push_back(wrap_bytes[i]);
            @(posedge clk); #1;
        end
        bus.TX_VALID = 1'b0;
        repeat (38) @(posedge clk);
        #1 bus.TX_DATA = wrap_bytes[3]; bus.TX_VALID = 1'b1; exp_q.push_back(wrap_bytes[3]);
        @(negedge clk);
        check("pushpop_count_before", 32'(bus.FIFO_COUNT), 32'd2);
        @(posedge clk); #1 bus.TX_VALID = 1'b0;
        @(negedge clk);
        check("pushpop_count_after", 32'(bus.FIFO_COUNT), 32'd2);
        wait_done("pushpop", 300);

        // Reset during data bit 3 of a frame; nothing is expected on the line.
        f0 = frames;
        bus.TX_DATA = 8'h96; bus.TX_VALID = 1'b1;
        @(posedge clk); #1 bus.TX_DATA = 8'h69;
        @(posedge clk); #1 bus.TX_VALID = 1'b0;
        repeat (17) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", 32'(bus.TX), 32'd1);
        check("midrst_count", 32'(bus.FIFO_COUNT), 32'd0);
        check("midrst_busy", 32'(bus.BUSY), 32'd0);
        check("midrst_ready", 32'(bus.TX_READY), 32'd1);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("midrst_no_frames", 32'(frames - f0), 32'd0);
        check("midrst_tx_idle", 32'(bus.TX), 32'd1);

        // Default parameters: start bit of 0xFF is the whole low run.
        @(posedge clk); #1 bus2.TX_DATA = 8'hFF; bus2.TX_VALID = 1'b1;
        @(posedge clk); #1 bus2.TX_VALID = 1'b0;
        n = 0;
        while (bus2.TX !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (bus2.TX !== 1'b0) begin
            check("def_start_seen", 32'(bus2.TX), 32'd0);
        end else begin
            n = 0;
            while (bus2.TX === 1'b0 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            check("def_start_width", 32'(n), 32'd2604);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL provide parameter CLK_HZ, default 25000000, input clock frequency in Hz.
REQ-002 SHALL provide parameter BAUD, default 9600, serial bit rate; CPB = CLK_HZ/BAUD, integer-truncated, CPB >= 2.
REQ-003 SHALL provide parameter FIFO_DEPTH, default 16, byte FIFO depth, power of two, 2..256.
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL provide port CLK_25MHZ  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL provide port RESET_N  input  1  asynchronous active-low reset.
REQ-007 SHALL provide port TX_DATA  input  8  byte to enqueue.
REQ-008 SHALL provide port TX_VALID  input  1  enqueue request.
REQ-009 SHALL provide port TX_READY  output  1  FIFO not full.
REQ-010 SHALL provide port TX  output  1  serial line: idle high, 8N1, LSB first.
REQ-011 SHALL provide port BUSY  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-012 SHALL provide port FIFO_COUNT  output  clog2(FIFO_DEPTH)+1  bytes currently queued.

Function
REQ-013 SHALL accept a byte on a rising edge when TX_VALID=1 and TX_READY=1; no other condition enqueues.
REQ-014 SHALL drive TX_READY = (FIFO_COUNT != FIFO_DEPTH), combinational from registered count only, never from TX_VALID.
REQ-015 SHALL leave FIFO contents and count unchanged when TX_VALID=1 while full; the byte is dropped and no error is flagged.
REQ-016 SHALL leave FIFO_COUNT unchanged on a cycle with simultaneous push and pop, with both operations taking effect.
REQ-017 SHALL use FIFO pointers that wrap modulo FIFO_DEPTH and preserve byte order across wrap.
REQ-018 SHALL implement the FSM states IDLE, START, DATA, STOP with registered TX output.
REQ-019 SHALL, in IDLE with FIFO_COUNT>0, pop the head byte into the shift register and enter START on the next edge.
REQ-020 SHALL, in START, drive TX=0 for exactly CPB cycles, then enter DATA.
REQ-021 SHALL, in DATA, drive shift-register bit 0 for CPB cycles per bit, shift right after each bit, and enter STOP after 8 bits (3-bit counter 0..7).
REQ-022 SHALL, in STOP, drive TX=1 for exactly CPB cycles.
REQ-023 SHALL, on the last STOP cycle with FIFO non-empty, pop the next byte and enter START directly, giving back-to-back frames with no idle gap.
REQ-024 SHALL, on the last STOP cycle with FIFO empty, enter IDLE.
REQ-025 SHALL use a bit timer that counts CPB-1 down to 0, reloads on every bit boundary, and whose width is clog2(CPB).
REQ-026 SHALL make every frame exactly 10*CPB cycles.
REQ-027 SHALL take TX low exactly 2 cycles after the edge that accepts a byte into an empty FIFO while IDLE (count=1 at +1, TX=0 at +2).
REQ-028 SHALL drive BUSY = (state != IDLE) or (FIFO_COUNT != 0).

Reset
REQ-029 SHALL, while RESET_N=0, force TX=1, state=IDLE, FIFO empty, FIFO_COUNT=0, TX_READY=1, BUSY=0, and timer/bit counter=0, asynchronously.
REQ-030 SHALL abort any frame in progress on reset assertion mid-frame, discard queued bytes, and hold TX at 1 from assertion onward.
REQ-031 SHALL leave FIFO data storage uninitialised by reset; only pointers and count are reset.
REQ-032 SHALL synchronise RESET_N deassertion externally; the block SHALL sample no TX_VALID during the deassertion cycle.

Verification (CLK_HZ=4, BAUD=1, so CPB=4; FIFO_DEPTH=4)
REQ-033 SHALL verify single byte: push 0x55 while idle -> TX=0 at +2 for 4 cycles, then 1,0,1,0,1,0,1,0 (4 cycles each), then 1 for 4; BUSY falls after 42 cycles total.
REQ-034 SHALL verify back-to-back: push 0xA3, 0x0F on consecutive cycles -> two 40-cycle frames with the second start bit immediately after the first stop bit; decoded bytes are 0xA3 then 0x0F.
REQ-035 SHALL verify full FIFO: push 5 bytes with TX_VALID held -> 1st popped, then 4 queued, TX_READY=0 when count=4; a further push while full is dropped and the line carries exactly 5 frames.
REQ-036 SHALL verify simultaneous push/pop: push on the last STOP cycle with count=2 -> count stays 2 and order is preserved across pointer wrap.
REQ-037 SHALL verify reset mid-frame: assert RESET_N=0 during DATA bit 3 -> TX=1 without waiting for an edge, count=0, no further frames after release.
REQ-038 SHALL verify default parameters: CPB=2604; start-bit width measured at 2604 cycles.
